m68k_bus_arbiter: RTL and testbench
===================================

# m68k_bus_arbiter

Owns the 68000 bus mastership protocol (BR/BG/BGACK) on behalf of the Pi-side bus-cycle engine and shares the Amiga bus between that engine and external DMA masters. It gates the engine's cycle starts, drives M68K_BG_n, and tells the bus drivers when to tri-state. It runs entirely in the PI_CLK domain and samples the 7 MHz bus clock and arbitration pins through synchronizers.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop depth of every asynchronous-input synchronizer (minimum 2).
- GRANT_TIMEOUT, 16: number of M68K_CLK falling edges allowed from BG_n assertion to BGACK_n assertion.
- RECLAIM_DELAY, 1: number of M68K_CLK falling edges with bus AS_n negated that must be seen after BGACK_n release before the bus is re-owned.

Ports:
- PI_CLK  in  1  sole clock, 200 MHz.
- RESET_n  in  1  synchronous active-low reset.
- M68K_CLK  in  1  asynchronous 7 MHz bus clock, sampled only.
- M68K_BR_n  in  1  asynchronous bus request from an external master.
- M68K_BGACK_n  in  1  asynchronous bus grant acknowledge.
- bus_as_n  in  1  asynchronous AS_n as seen on the bus.
- txn_req  in  1  engine requests a cycle; level, held until txn_ack.
- txn_busy  in  1  engine cycle in flight, from txn_ack until S7 completes.
- err_clr  in  1  one-cycle pulse that clears timeout_err.
- txn_ack  out  1  one-cycle pulse meaning the engine may start its cycle.
- M68K_BG_n  out  1  bus grant to the external master.
- bus_oe_n  out  1  0 = the engine drives AS/UDS/LDS/RW/FC/address.
- arb_state  out  3  current state encoding, for the status register.
- timeout_err  out  1  sticky flag set on a grant timeout.

## Operation

- Every asynchronous input passes through a SYNC_STAGES synchronizer.
- c7m_fall is a one-PI_CLK strobe generated on the synchronized M68K_CLK 1→0 transition. All state transitions happen only on c7m_fall, except WAIT_FREE entry on reset and txn_ack issue as described below.
- States:
  - WAIT_FREE (0)
  - OWN_IDLE (1)
  - OWN_BUSY (2)
  - GRANT_PEND (3)
  - RELEASED (4)
  - RECLAIM (5)
- WAIT_FREE: bus_oe_n=1, BG_n=1. Go to OWN_IDLE after 2 consecutive c7m_fall with BGACK_n=1 and bus_as_n=1.
- OWN_IDLE: bus_oe_n=0, BG_n=1. On c7m_fall:
  - if pri_pi=1 and txn_req=1: pulse txn_ack, go to OWN_BUSY, clear pri_pi;
  - else if BR_n=0: assert BG_n=0, go to GRANT_PEND, load timeout counter;
  - else if txn_req=1: pulse txn_ack, go to OWN_BUSY.
- OWN_BUSY: wait for txn_busy=0 sampled on a c7m_fall, then go to OWN_IDLE. BR_n is never granted mid-cycle.
- GRANT_PEND: bus_oe_n=1, BG_n=0. On c7m_fall:
  - BGACK_n=0: BG_n=1, go to RELEASED;
  - else BR_n=1 (request withdrawn): BG_n=1, go to OWN_IDLE;
  - else the counter decrements; on reaching 0: BG_n=1, timeout_err=1, go to OWN_IDLE.
- RELEASED: bus_oe_n=1, BG_n=1. On c7m_fall with BGACK_n=1, go to RECLAIM and load the reclaim counter with RECLAIM_DELAY.
- RECLAIM: bus_oe_n=1. Each c7m_fall with bus_as_n=1 decrements the counter; bus_as_n=0 reloads it. At 0: set pri_pi=1, go to OWN_IDLE.
- pri_pi guarantees the engine one cycle after every external tenure, so BR cannot starve the Pi.
- timeout_err: set has priority over err_clr when both occur in the same cycle.
- txn_req dropped before txn_ack: no ack, no state change.

## Timing

- Reset values: state=WAIT_FREE, bus_oe_n=1, M68K_BG_n=1, txn_ack=0, timeout_err=0, pri_pi=0, all synchronizers set to 1 (negated), counters 0.
- Reset asserted mid-tenure: BG_n is released immediately. bus_oe_n stays 1 until WAIT_FREE proves the bus is free, so there is never contention with a master still holding BGACK.
- Input-to-strobe latency is SYNC_STAGES+1 PI_CLK cycles.
- txn_ack is registered and aligned to the c7m_fall strobe. The engine sees it before the next M68K_CLK falling edge.
- BG_n assertion and negation occur one PI_CLK after the deciding c7m_fall.
- bus_oe_n changes on the same PI_CLK edge as the state register.
- The GRANT_TIMEOUT counter is 8 bits wide and saturates at 0.

## Test plan

- Reset release, BGACK_n=1, AS_n=1 → OWN_IDLE after 2 c7m falls, bus_oe_n=0. txn_req=1 → one txn_ack, state=2.
- BR_n=0 while txn_busy=1 → BG_n stays 1 until txn_busy drops. BG_n=0 on the next c7m_fall and bus_oe_n=1.
- Full tenure: BR_n low, BGACK_n low 3 falls later, BR_n released, BGACK_n high after 20 falls → BG_n=1 at BGACK, RECLAIM 1 fall. With txn_req and BR_n both low, txn_ack wins (pri_pi).
- BR_n held low, BGACK_n never asserted → BG_n=1 after 16 c7m falls, timeout_err=1. err_clr pulse → 0.
- BR_n pulses low for 2 falls then withdraws → BG_n negates, OWN_IDLE, timeout_err=0.
- RESET_n asserted during RELEASED with BGACK_n still low → BG_n=1, bus_oe_n=1. bus_oe_n stays 1 until 2 falls after BGACK_n rises.

Source files
------------

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus-mastership arbiter: shares the Amiga bus between the Pi bus-cycle engine
// and external DMA masters (BR/BG/BGACK), stepping only on synchronized M68K_CLK falls.
module m68k_bus_arbiter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = 16,
  parameter int RECLAIM_DELAY = 1
) (
  input  logic       PI_CLK,
  input  logic       RESET_n,
  input  logic       M68K_CLK,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  input  logic       bus_as_n,
  input  logic       txn_req,
  input  logic       txn_busy,
  input  logic       err_clr,
  output logic       txn_ack,
  output logic       M68K_BG_n,
  output logic       bus_oe_n,
  output logic [2:0] arb_state,
  output logic       timeout_err
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    WAIT_FREE  = 3'd0,
    OWN_IDLE   = 3'd1,
    OWN_BUSY   = 3'd2,
    GRANT_PEND = 3'd3,
    RELEASED   = 3'd4,
    RECLAIM    = 3'd5
  } state_t;

  logic [SS-1:0] r_sync_clk;
  logic [SS-1:0] r_sync_br;
  logic [SS-1:0] r_sync_bgack;
  logic [SS-1:0] r_sync_as;
  logic          r_clk_prev;
  logic          r_c7m_fall;

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_pri_pi;
  logic          r_bg_n;
  logic          r_oe_n;
  logic          r_ack;
  logic          r_err;

  logic          w_clk_s;
  logic          w_br_s;
  logic          w_bgack_s;
  logic          w_as_s;
  logic          w_fall_edge;

  assign w_clk_s     = r_sync_clk[SS-1];
  assign w_br_s      = r_sync_br[SS-1];
  assign w_bgack_s   = r_sync_bgack[SS-1];
  assign w_as_s      = r_sync_as[SS-1];
  assign w_fall_edge = r_clk_prev & ~w_clk_s;

  // Synchronizers preset to the negated level so reset never fabricates a request or edge
  always_ff @(posedge PI_CLK) begin
    if (!RESET_n) begin
      r_sync_clk   <= '1;
      r_sync_br    <= '1;
      r_sync_bgack <= '1;
      r_sync_as    <= '1;
      r_clk_prev   <= 1'b1;
      r_c7m_fall   <= 1'b0;
    end else begin
      r_sync_clk   <= {r_sync_clk[SS-2:0], M68K_CLK};
      r_sync_br    <= {r_sync_br[SS-2:0], M68K_BR_n};
      r_sync_bgack <= {r_sync_bgack[SS-2:0], M68K_BGACK_n};
      r_sync_as    <= {r_sync_as[SS-2:0], bus_as_n};
      r_clk_prev   <= w_clk_s;
      r_c7m_fall   <= w_fall_edge;
    end
  end

  always_ff @(posedge PI_CLK) begin
    if (!RESET_n) begin
      r_state  <= WAIT_FREE;
      r_cnt    <= 8'd0;
      r_pri_pi <= 1'b0;
      r_bg_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      // A timeout set later in this block overrides a coincident clear
      if (err_clr) r_err <= 1'b0;
      if (r_c7m_fall) begin
        case (r_state)
          WAIT_FREE: begin
            if (w_bgack_s && w_as_s) begin
              if (r_cnt >= 8'd1) begin
                r_cnt   <= 8'd0;
                r_oe_n  <= 1'b0;
                r_state <= OWN_IDLE;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end else begin
              r_cnt <= 8'd0;
            end
          end
          OWN_IDLE: begin
            if (r_pri_pi && txn_req) begin
              r_ack    <= 1'b1;
              r_pri_pi <= 1'b0;
              r_state  <= OWN_BUSY;
            end else if (!w_br_s) begin
              r_bg_n  <= 1'b0;
              r_oe_n  <= 1'b1;
              r_cnt   <= 8'(GRANT_TIMEOUT);
              r_state <= GRANT_PEND;
            end else if (txn_req) begin
              r_ack   <= 1'b1;
              r_state <= OWN_BUSY;
            end
          end
          OWN_BUSY: begin
            if (!txn_busy) r_state <= OWN_IDLE;
          end
          GRANT_PEND: begin
            if (!w_bgack_s) begin
              r_bg_n  <= 1'b1;
              r_state <= RELEASED;
            end else if (w_br_s) begin
              r_bg_n  <= 1'b1;
              r_oe_n  <= 1'b0;
              r_state <= OWN_IDLE;
            end else if (r_cnt <= 8'd1) begin
              r_cnt   <= 8'd0;
              r_bg_n  <= 1'b1;
              r_oe_n  <= 1'b0;
              r_err   <= 1'b1;
              r_state <= OWN_IDLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          RELEASED: begin
            if (w_bgack_s) begin
              r_cnt   <= 8'(RECLAIM_DELAY);
              r_state <= RECLAIM;
            end
          end
          RECLAIM: begin
            // The external master's last AS must be fully gone before we drive the bus
            if (!w_as_s) begin
              r_cnt <= 8'(RECLAIM_DELAY);
            end else if (r_cnt <= 8'd1) begin
              r_cnt    <= 8'd0;
              r_pri_pi <= 1'b1;
              r_oe_n   <= 1'b0;
              r_state  <= OWN_IDLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          default: begin
            r_bg_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= WAIT_FREE;
          end
        endcase
      end
    end
  end

  assign txn_ack     = r_ack;
  assign M68K_BG_n   = r_bg_n;
  assign bus_oe_n    = r_oe_n;
  assign arb_state   = r_state;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Randomized bench for m68k_bus_arbiter: an engine model and an external-master model
// drive the pins while a fall-by-fall protocol model predicts state, grant, OE, error and acks.
module tb_m68k_bus_arbiter;

  localparam int GT = 16;
  localparam int RD = 1;

  logic       PI_CLK;
  logic       RESET_n;
  logic       M68K_CLK;
  logic       M68K_BR_n;
  logic       M68K_BGACK_n;
  logic       bus_as_n;
  logic       txn_req;
  logic       txn_busy;
  logic       err_clr;
  logic       txn_ack;
  logic       M68K_BG_n;
  logic       bus_oe_n;
  logic [2:0] arb_state;
  logic       timeout_err;

  m68k_bus_arbiter #(
    .SYNC_STAGES  (2),
    .GRANT_TIMEOUT(GT),
    .RECLAIM_DELAY(RD)
  ) dut (
    .PI_CLK      (PI_CLK),
    .RESET_n     (RESET_n),
    .M68K_CLK    (M68K_CLK),
    .M68K_BR_n   (M68K_BR_n),
    .M68K_BGACK_n(M68K_BGACK_n),
    .bus_as_n    (bus_as_n),
    .txn_req     (txn_req),
    .txn_busy    (txn_busy),
    .err_clr     (err_clr),
    .txn_ack     (txn_ack),
    .M68K_BG_n   (M68K_BG_n),
    .bus_oe_n    (bus_oe_n),
    .arb_state   (arb_state),
    .timeout_err (timeout_err)
  );

  initial PI_CLK = 1'b0;
  always #5 PI_CLK = ~PI_CLK;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt  = 0;

  always @(negedge PI_CLK) if (txn_ack === 1'b1) ack_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec states 0..5, plain integer counters of qualifying falls
  int m_st, m_free, m_tmo, m_rc, m_pri, m_err, m_acks;

  function automatic void m_reset();
    m_st = 0; m_free = 0; m_tmo = 0; m_rc = 0; m_pri = 0; m_err = 0;
  endfunction

  function automatic void model_fall(input bit clr);
    bit set_err;
    set_err = 1'b0;
    case (m_st)
      0: begin
        if (M68K_BGACK_n && bus_as_n) m_free++; else m_free = 0;
        if (m_free == 2) begin m_st = 1; m_free = 0; end
      end
      1: begin
        if (m_pri != 0 && txn_req) begin m_acks++; m_st = 2; m_pri = 0; end
        else if (!M68K_BR_n) begin m_st = 3; m_tmo = GT; end
        else if (txn_req) begin m_acks++; m_st = 2; end
      end
      2: if (!txn_busy) m_st = 1;
      3: begin
        if (!M68K_BGACK_n) m_st = 4;
        else if (M68K_BR_n) m_st = 1;
        else begin
          if (m_tmo > 0) m_tmo--;
          if (m_tmo == 0) begin set_err = 1'b1; m_st = 1; end
        end
      end
      4: if (M68K_BGACK_n) begin m_st = 5; m_rc = RD; end
      5: begin
        if (!bus_as_n) m_rc = RD;
        else begin
          if (m_rc > 0) m_rc--;
          if (m_rc == 0) begin m_pri = 1; m_st = 1; end
        end
      end
      default: m_st = 0;
    endcase
    if (set_err) m_err = 1;
    else if (clr) m_err = 0;
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, "_state"}, 32'(arb_state), 32'(m_st));
    chk({pfx, "_bg_n"}, 32'(M68K_BG_n), (m_st == 3) ? 32'd0 : 32'd1);
    chk({pfx, "_oe_n"}, 32'(bus_oe_n), (m_st == 1 || m_st == 2) ? 32'd0 : 32'd1);
    chk({pfx, "_err"}, 32'(timeout_err), 32'(m_err));
    chk({pfx, "_acks"}, 32'(ack_cnt), 32'(m_acks));
  endtask

  int hold = 0, dly = 0, busy_left = 0, last_ack = 0;
  bit rst_done = 1'b0;

  task automatic drive_inputs(input int mode);
    if (ack_cnt != last_ack) begin
      last_ack  = ack_cnt;
      txn_req   = 1'b0;
      txn_busy  = 1'b1;
      busy_left = $urandom_range(0, 3);
    end else if (txn_busy) begin
      if (busy_left == 0) txn_busy = 1'b0; else busy_left--;
    end else if (!txn_req) begin
      txn_req = ($urandom_range(0, 2) == 0);
    end else if ($urandom_range(0, 7) == 0) begin
      txn_req = 1'b0;
    end
    case (mode)
      0: begin
        if ($urandom_range(0, 5) == 0) M68K_BR_n = ~M68K_BR_n;
        if ($urandom_range(0, 5) == 0) M68K_BGACK_n = ~M68K_BGACK_n;
        if ($urandom_range(0, 5) == 0) bus_as_n = ~bus_as_n;
      end
      1: begin
        if (!M68K_BGACK_n) begin
          if (hold == 0) begin M68K_BGACK_n = 1'b1; bus_as_n = 1'b1; end
          else begin hold--; bus_as_n = ($urandom_range(0, 1) == 1); end
        end else if (!M68K_BG_n) begin
          if (dly == 0) begin
            M68K_BGACK_n = 1'b0; M68K_BR_n = 1'b1; hold = $urandom_range(2, 20);
          end else begin
            dly--;
            if ($urandom_range(0, 5) == 0) M68K_BR_n = 1'b1;
          end
        end else begin
          bus_as_n = ($urandom_range(0, 4) != 0);
          if (M68K_BR_n && $urandom_range(0, 2) == 0) begin
            M68K_BR_n = 1'b0; dly = $urandom_range(0, 3);
          end
        end
      end
      default: begin
        M68K_BR_n = 1'b0; M68K_BGACK_n = 1'b1; bus_as_n = 1'b1;
      end
    endcase
  endtask

  // One 12-PI_CLK bus-clock period: low half then high half, starting at a negedge
  task automatic period(input int mode, input bit allow_rst);
    bit clr;
    clr = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
    M68K_CLK = 1'b0;
    model_fall(clr);
    repeat (3) @(negedge PI_CLK);
    err_clr = clr;
    @(negedge PI_CLK);
    err_clr = 1'b0;
    @(negedge PI_CLK);
    check_all("run");
    @(negedge PI_CLK);
    M68K_CLK = 1'b1;
    if (allow_rst && !rst_done && m_st == 4 && !M68K_BGACK_n) begin
      rst_done = 1'b1;
      RESET_n  = 1'b0;
      repeat (3) @(negedge PI_CLK);
      m_reset();
      check_all("midrst");
      chk("midrst_ack", 32'(txn_ack), 32'd0);
      RESET_n = 1'b1;
      repeat (3) @(negedge PI_CLK);
    end else begin
      drive_inputs(mode);
      repeat (6) @(negedge PI_CLK);
    end
  endtask

  initial begin
    RESET_n      = 1'b0;
    M68K_CLK     = 1'b1;
    M68K_BR_n    = 1'b1;
    M68K_BGACK_n = 1'b1;
    bus_as_n     = 1'b1;
    txn_req      = 1'b0;
    txn_busy     = 1'b0;
    err_clr      = 1'b0;
    m_acks       = 0;
    m_reset();
    repeat (4) @(negedge PI_CLK);
    check_all("reset");
    chk("reset_ack", 32'(txn_ack), 32'd0);
    RESET_n = 1'b1;
    repeat (6) @(negedge PI_CLK);

    for (int i = 0; i < 200; i++) period(1, 1'b0);
    for (int i = 0; i < 150; i++) period(0, 1'b0);
    for (int i = 0; i < 40;  i++) period(2, 1'b0);
    for (int i = 0; i < 300; i++) period(1, 1'b1);
    for (int i = 0; i < 60;  i++) period(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
